// File: rtl/memory_types_pkg.sv
// Shared types for the memory arbiter slice: RAM status codes, data word and
// arbiter FSM states.
package memory_types_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_I  = 2'd1,
    GNT_DR = 2'd2,
    GNT_DW = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and RAM side signals of the memory arbiter. The slave modport is
// the arbiter's view; master is the surrounding processor/RAM environment.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  import memory_types_pkg::*;

  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic [DATA_W-1:0] iload;
  logic              iwait;

  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic [DATA_W-1:0] dload;
  logic              dwait;

  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  ramstate_t         ramstate;
  logic              ram_err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, ram_err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, ram_err
  );

endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access. Data wins
// arbitration unless instruction fetch has been passed over MAX_DSTREAK times.
module mem_arbiter
  import memory_types_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_DSTREAK = 4
) (
  input logic           clk,
  input logic           n_rst,
  mem_arbiter_if.slave  bus
);

  localparam logic [3:0] MAX_S = 4'(MAX_DSTREAK);

  arb_state_t state;
  logic [3:0] streak;
  logic       err_q;
  logic       owner_en;
  logic       done;
  logic       err_now;

  // Owner's live enable; dropping it mid-grant aborts the transaction.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    owner_en = 1'b0;
    case (state)
      GNT_I:   owner_en = bus.iREN;
      GNT_DR:  owner_en = bus.dREN;
      GNT_DW:  owner_en = bus.dWEN;
      default: owner_en = 1'b0;
    endcase
  end

  assign done    = owner_en && (bus.ramstate == ACCESS);
  assign err_now = (state != IDLE) && (bus.ramstate == ERROR);

  always_ff @(posedge clk or negedge n_rst) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    if (!n_rst) begin
      state  <= IDLE;
      streak <= '0;
      err_q  <= 1'b0;
    end else begin
      if (err_now) err_q <= 1'b1;

      case (state)
        IDLE: begin
          if (bus.iREN && streak == MAX_S) begin
            state  <= GNT_I;
            streak <= '0;
          end else if (bus.dWEN) begin
            state  <= GNT_DW;
            streak <= (streak == MAX_S) ? streak : streak + 4'd1;
          end else if (bus.dREN) begin
            state  <= GNT_DR;
            streak <= (streak == MAX_S) ? streak : streak + 4'd1;
          end else if (bus.iREN) begin
            state  <= GNT_I;
            streak <= '0;
          end
        end
        default: begin
          // Completion and abort both return through a single IDLE bubble.
          if (!owner_en || done) state <= IDLE;
        end
      endcase

      // Streak only counts while instruction fetch is actually waiting.
      if (!bus.iREN) streak <= '0;
    end
  end

  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = {ADDR_W{1'b0}};
    bus.ramstore = {DATA_W{1'b0}};
    case (state)
      GNT_I: begin
        bus.ramREN  = bus.iREN;
        bus.ramaddr = bus.iaddr;
      end
      GNT_DR: begin
        bus.ramREN  = bus.dREN;
        bus.ramaddr = bus.daddr;
      end
      GNT_DW: begin
        bus.ramWEN   = bus.dWEN;
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
      end
      default: ;
    endcase
  end

  assign bus.iwait   = !((state == GNT_I) && done);
  assign bus.dwait   = !(((state == GNT_DR) || (state == GNT_DW)) && done);
  assign bus.iload   = bus.ramload;
  assign bus.dload   = bus.ramload;
  // Error is flagged in the very cycle it is first seen, then held.
  assign bus.ram_err = err_q || err_now;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: latency, priority, write/read overlap,
// streak guard, abort, sticky error and mid-grant reset.
module tb_mem_arbiter;
  import memory_types_pkg::*;

  logic clk = 1'b0;
  logic n_rst;
  int   checks = 0;
  int   errors = 0;

  mem_arbiter_if bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DSTREAK(4)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int d_grants;
    logic got_i;

    n_rst        = 1'b0;
    bus.iREN     = 1'b0;
    bus.iaddr    = '0;
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    bus.ramload  = '0;
    bus.ramstate = FREE;

    // Reset values while reset is held and after release.
    #3;
    check("rst_state", 64'(dut.state), 64'(IDLE));
    check("rst_ramREN", 64'(bus.ramREN), 64'd0);
    check("rst_iwait", 64'(bus.iwait), 64'd1);
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    mid();
    check("rel_state", 64'(dut.state), 64'(IDLE));
    check("rel_streak", 64'(dut.streak), 64'd0);
    check("rel_ram_err", 64'(bus.ram_err), 64'd0);
    check("rel_ramWEN", 64'(bus.ramWEN), 64'd0);
    check("rel_ramaddr", 64'(bus.ramaddr), 64'd0);
    check("rel_ramstore", 64'(bus.ramstore), 64'd0);
    check("rel_dwait", 64'(bus.dwait), 64'd1);

    // I fetch, two BUSY cycles then ACCESS.
    nxt(); bus.iREN = 1'b1; bus.iaddr = 32'h40;
    mid(); check("t1_c0_ramREN", 64'(bus.ramREN), 64'd0);
    nxt(); bus.ramstate = BUSY;
    mid(); check("t1_c1_ramREN", 64'(bus.ramREN), 64'd1);
           check("t1_c1_ramaddr", 64'(bus.ramaddr), 64'h40);
           check("t1_c1_iwait", 64'(bus.iwait), 64'd1);
    nxt();
    mid(); check("t1_c2_iwait", 64'(bus.iwait), 64'd1);
    nxt(); bus.ramstate = ACCESS; bus.ramload = 32'h8C22_0004;
    mid(); check("t1_c3_iwait", 64'(bus.iwait), 64'd0);
           check("t1_c3_iload", 64'(bus.iload), 64'h8C22_0004);
    nxt(); bus.iREN = 1'b0; bus.ramstate = FREE;
    mid(); check("t1_c4_state", 64'(dut.state), 64'(IDLE));
           check("t1_c4_iwait", 64'(bus.iwait), 64'd1);

    // I and D together: D first, one bubble, then I.
    nxt(); bus.iREN = 1'b1; bus.iaddr = 32'h44; bus.dREN = 1'b1; bus.daddr = 32'h100;
           bus.ramstate = ACCESS;
    mid(); check("t2_c0_state", 64'(dut.state), 64'(IDLE));
    nxt();
    mid(); check("t2_c1_state", 64'(dut.state), 64'(GNT_DR));
           check("t2_c1_ramaddr", 64'(bus.ramaddr), 64'h100);
           check("t2_c1_dwait", 64'(bus.dwait), 64'd0);
           check("t2_c1_iwait", 64'(bus.iwait), 64'd1);
    nxt(); bus.dREN = 1'b0;
    mid(); check("t2_c2_state", 64'(dut.state), 64'(IDLE));
           check("t2_c2_ramREN", 64'(bus.ramREN), 64'd0);
    nxt();
    mid(); check("t2_c3_state", 64'(dut.state), 64'(GNT_I));
           check("t2_c3_ramaddr", 64'(bus.ramaddr), 64'h44);
           check("t2_c3_iwait", 64'(bus.iwait), 64'd0);
    nxt(); bus.iREN = 1'b0; bus.ramstate = FREE;
    mid(); check("t2_c4_state", 64'(dut.state), 64'(IDLE));

    // dREN and dWEN together: serviced as a write.
    nxt(); bus.dWEN = 1'b1; bus.dREN = 1'b1; bus.daddr = 32'h200; bus.dstore = 32'hDEAD_BEEF;
           bus.ramstate = BUSY;
    mid();
    nxt();
    mid(); check("t3_state", 64'(dut.state), 64'(GNT_DW));
           check("t3_ramWEN", 64'(bus.ramWEN), 64'd1);
           check("t3_ramREN", 64'(bus.ramREN), 64'd0);
           check("t3_ramstore", 64'(bus.ramstore), 64'hDEAD_BEEF);
           check("t3_dwait_busy", 64'(bus.dwait), 64'd1);
    nxt(); bus.ramstate = ACCESS;
    mid(); check("t3_dwait_acc", 64'(bus.dwait), 64'd0);
    nxt(); bus.dWEN = 1'b0; bus.dREN = 1'b0; bus.ramstate = FREE;
    mid(); check("t3_idle", 64'(dut.state), 64'(IDLE));

    // Withdrawn read: enable drops in the abort cycle, no wait-low pulse.
    nxt(); bus.dREN = 1'b1; bus.daddr = 32'h240; bus.ramstate = BUSY;
    mid();
    nxt();
    mid(); check("ab_ramREN_on", 64'(bus.ramREN), 64'd1);
    nxt(); bus.dREN = 1'b0;
    mid(); check("ab_ramREN_off", 64'(bus.ramREN), 64'd0);
           check("ab_dwait", 64'(bus.dwait), 64'd1);
    nxt();
    mid(); check("ab_state", 64'(dut.state), 64'(IDLE));

    // Streak guard: continuous D reads with I pending.
    nxt(); bus.iREN = 1'b1; bus.iaddr = 32'h80; bus.dREN = 1'b1; bus.daddr = 32'h180;
           bus.ramstate = ACCESS;
    d_grants = 0;
    got_i = 1'b0;
    for (int c = 0; c < 30 && !got_i; c++) begin
      mid();
      if (dut.state == GNT_DR) d_grants++;
      if (dut.state == GNT_I) got_i = 1'b1;
      else nxt();
    end
    check("st_i_granted", 64'(got_i), 64'd1);
    check("st_d_grants", 64'(d_grants), 64'd4);
    check("st_streak_gnt_i", 64'(dut.streak), 64'd0);
    nxt(); bus.iREN = 1'b0; bus.dREN = 1'b0; bus.ramstate = FREE;
    mid(); check("st_streak_after", 64'(dut.streak), 64'd0);

    // ERROR for three cycles then ACCESS during GNT_DR.
    nxt(); bus.dREN = 1'b1; bus.daddr = 32'h300;
    mid(); check("er_pre", 64'(bus.ram_err), 64'd0);
    nxt(); bus.ramstate = ERROR;
    mid(); check("er_c1_state", 64'(dut.state), 64'(GNT_DR));
           check("er_c1_ram_err", 64'(bus.ram_err), 64'd1);
           check("er_c1_dwait", 64'(bus.dwait), 64'd1);
    for (int c = 2; c <= 3; c++) begin
      nxt();
      mid(); check("er_dwait", 64'(bus.dwait), 64'd1);
             check("er_ram_err", 64'(bus.ram_err), 64'd1);
    end
    nxt(); bus.ramstate = ACCESS;
    mid(); check("er_acc_dwait", 64'(bus.dwait), 64'd0);
    nxt(); bus.dREN = 1'b0; bus.ramstate = FREE;
    mid(); check("er_sticky", 64'(bus.ram_err), 64'd1);
           check("er_idle", 64'(dut.state), 64'(IDLE));

    // Reset pulsed in the middle of a write grant.
    nxt(); bus.dWEN = 1'b1; bus.daddr = 32'h400; bus.dstore = 32'h1234; bus.ramstate = BUSY;
    mid();
    nxt();
    mid(); check("rs_ramWEN_on", 64'(bus.ramWEN), 64'd1);
    n_rst = 1'b0;
    #1;
    check("rs_ramWEN_async", 64'(bus.ramWEN), 64'd0);
    check("rs_state_async", 64'(dut.state), 64'(IDLE));
    bus.dWEN = 1'b0;
    nxt();
    nxt(); n_rst = 1'b1;
    mid(); check("rs_state", 64'(dut.state), 64'(IDLE));
           check("rs_iwait", 64'(bus.iwait), 64'd1);
           check("rs_dwait", 64'(bus.dwait), 64'd1);
           check("rs_ram_err", 64'(bus.ram_err), 64'd0);
           check("rs_ramWEN", 64'(bus.ramWEN), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
